canright_aes_sbox: RTL and testbench

CANRIGHT_AES_SBOX -- requirements
Module: canright_aes_sbox

---
 rtl/canright_aes_sbox.sv | 236 +++++++++++++++++++++++
 tb/tb_canright_aes_sbox.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canright_aes_sbox.sv
// ============================================================================
// canright_aes_sbox
//
// Purpose
//   Combined AES S-box / inverse S-box with a single registered output.
//   The GF(2^8) multiplicative inverse is computed in the composite field
//   GF(((2^2)^2)^2). Normal bases are used at every level:
//     GF(4)   over GF(2)  : [W^2, W]     where W^2 + W + 1 = 0
//     GF(16)  over GF(4)  : [Y^4, Y]     where Y^2 + Y + N = 0,  N  = W^2
//     GF(256) over GF(16) : [Z^16, Z]    where Z^2 + Z + nu = 0, nu = N*Y
//   In every tower word the high half holds the coefficient of the
//   conjugate (Y^4 / Z^16 / W^2) and the low half the coefficient of the
//   root itself (Y / Z / W).
//
//   The basis-change matrices between the AES polynomial basis and the
//   tower basis are derived at elaboration time from the roots W, Y and Z.
//   The roots are found inside GF(2^8) mod x^8+x^4+x^3+x+1. The derived
//   matrices are constants, so the datapath reduces to fixed XOR networks.
//   Nothing is stored as a 256-entry table.
//
//   Forward : Q = Aff(Inv(A))      = (L*M)*Inv_t(Minv*A) ^ 0x63
//   Inverse : Q = Inv(Aff^-1(A))   = M*Inv_t((Minv*Linv)*A ^ Minv*0x05)
//   L/Linv are the linear parts of the affine / inverse affine maps.
//   M maps tower to polynomial basis. Minv is the inverse of M.
//   encrypt picks one of the two input matrices and one of the two output
//   matrices. The single tower inverter Inv_t sits between them.
//
// Ports
//   clk      in   1  clock, rising edge active
//   rst_n    in   1  asynchronous active-low reset, clears Q to 0x00
//   A        in   8  input byte (bit 7 = MSB of the field element)
//   encrypt  in   1  1 = SubBytes, 0 = InvSubBytes
//   Q        out  8  registered result, one clock after A/encrypt sampled
// ============================================================================
module canright_aes_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic       encrypt,
    output logic [7:0] Q
);

    // ------------------------------------------------------------------
    // Polynomial-basis helpers, only used to build constant matrices
    // ------------------------------------------------------------------
    function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // First root (in counting order) of x^2 + x + c. Either root of the
    // pair gives a valid normal basis, because the pair is the basis.
    function automatic logic [7:0] poly_root(input logic [7:0] c);
        logic [7:0] cand;
        logic [7:0] root;
        logic       found;
        root  = 8'h00;
        found = 1'b0;
        for (int i = 2; i < 256; i++) begin
            cand = 8'(i);
            if (!found && ((poly_mul(cand, cand) ^ cand ^ c) == 8'h00)) begin
                root  = cand;
                found = 1'b1;
            end
        end
        return root;
    endfunction

    // Linear parts of the AES affine map and its inverse
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] aff_lin(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4);
    endfunction

    function automatic logic [7:0] inv_aff_lin(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6);
    endfunction

    // 8x8 GF(2) matrix stored as eight columns; column k is bits [8k+7:8k]
    function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (x[k]) acc = acc ^ m[8*k +: 8];
        end
        return acc;
    endfunction

    // Columns of M: the polynomial-basis value of each tower basis element
    function automatic logic [63:0] tower_basis();
        logic [7:0]  w, w2, y, y4, nu, z, z16;
        logic [2:0]  kb;
        logic [63:0] m;
        w   = poly_root(8'h01);
        w2  = poly_mul(w, w);
        y   = poly_root(w2);
        y4  = poly_mul(poly_mul(y, y), poly_mul(y, y));
        nu  = poly_mul(w2, y);
        z   = poly_root(nu);
        z16 = z;
        for (int s = 0; s < 4; s++) z16 = poly_mul(z16, z16);
        m = 64'h0;
        for (int k = 0; k < 8; k++) begin
            kb = 3'(k);
            m[8*k +: 8] = poly_mul(poly_mul(kb[0] ? w2 : w, kb[1] ? y4 : y),
                                   kb[2] ? z16 : z);
        end
        return m;
    endfunction

    // Inverse of a bijective matrix: column j is the preimage of e_j
    function automatic logic [63:0] mat_invert(input logic [63:0] m);
        logic [63:0] r;
        r = 64'h0;
        for (int j = 0; j < 8; j++) begin
            for (int t = 0; t < 256; t++) begin
                if (mat_apply(m, 8'(t)) == (8'h01 << j)) r[8*j +: 8] = 8'(t);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] in_inv_matrix(input logic [63:0] p2t);
        logic [63:0] r;
        r = 64'h0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mat_apply(p2t, inv_aff_lin(8'h01 << k));
        return r;
    endfunction

    function automatic logic [63:0] out_fwd_matrix(input logic [63:0] t2p);
        logic [63:0] r;
        r = 64'h0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = aff_lin(t2p[8*k +: 8]);
        return r;
    endfunction

    localparam logic [63:0] TOWER_TO_POLY = tower_basis();
    localparam logic [63:0] POLY_TO_TOWER = mat_invert(TOWER_TO_POLY);
    localparam logic [63:0] IN_INV_MAT    = in_inv_matrix(POLY_TO_TOWER);
    localparam logic [7:0]  IN_INV_CONST  = mat_apply(POLY_TO_TOWER, 8'h05);
    localparam logic [63:0] OUT_FWD_MAT   = out_fwd_matrix(TOWER_TO_POLY);

    localparam logic [1:0]  GF4_N   = 2'b10;    // N  = W^2
    localparam logic [3:0]  GF16_NU = 4'b0010;  // nu = W^2 * Y

    // ------------------------------------------------------------------
    // Tower-field arithmetic (this is the hardware inverter)
    // ------------------------------------------------------------------
    // GF(4), basis [W^2, W]: the product shares one AND term between halves
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic s;
        s = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ s, (a[0] & b[0]) ^ s};
    endfunction

    // Squaring in a normal basis is a swap; in GF(4) it is also the inverse
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] s;
        s = gf4_mul(GF4_N, gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {gf4_mul(a[3:2], b[3:2]) ^ s, gf4_mul(a[1:0], b[1:0]) ^ s};
    endfunction

    // (h,l) -> theta*(l,h), theta = (N*(h+l)^2 + h*l)^-1. Zero maps to zero.
    function automatic logic [3:0] gf16_inv(input logic [3:0] g);
        logic [1:0] hi, lo, t, ti;
        hi = g[3:2];
        lo = g[1:0];
        t  = gf4_mul(GF4_N, gf4_sq(hi ^ lo)) ^ gf4_mul(hi, lo);
        ti = gf4_sq(t);
        return {gf4_mul(ti, lo), gf4_mul(ti, hi)};
    endfunction

    // The same structure one level up, with nu in place of N
    function automatic logic [7:0] gf256_inv(input logic [7:0] g);
        logic [3:0] hi, lo, s, t, ti;
        hi = g[7:4];
        lo = g[3:0];
        s  = hi ^ lo;
        t  = gf16_mul(GF16_NU, gf16_mul(s, s)) ^ gf16_mul(hi, lo);
        ti = gf16_inv(t);
        return {gf16_mul(ti, lo), gf16_mul(ti, hi)};
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: combinational S-box
    // ------------------------------------------------------------------
    logic [7:0] fwd_in_p0;
    logic [7:0] inv_in_p0;
    logic [7:0] tower_in_p0;
    logic [7:0] tower_out_p0;
    logic [7:0] fwd_out_p0;
    logic [7:0] inv_out_p0;
    logic [7:0] sbox_p0;

    always_comb begin
        fwd_in_p0    = mat_apply(POLY_TO_TOWER, A);
        inv_in_p0    = mat_apply(IN_INV_MAT, A) ^ IN_INV_CONST;
        tower_in_p0  = encrypt ? fwd_in_p0 : inv_in_p0;
        tower_out_p0 = gf256_inv(tower_in_p0);
        fwd_out_p0   = mat_apply(OUT_FWD_MAT, tower_out_p0) ^ 8'h63;
        inv_out_p0   = mat_apply(TOWER_TO_POLY, tower_out_p0);
        sbox_p0      = encrypt ? fwd_out_p0 : inv_out_p0;
    end

    // ------------------------------------------------------------------
    // Stage p1: output register
    // ------------------------------------------------------------------
    logic [7:0] q_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1 <= 8'h00;
        end else begin
            q_p1 <= sbox_p0;
        end
    end

    assign Q = q_p1;

endmodule

// File: tb/tb_canright_aes_sbox.sv
// ============================================================================
// tb_canright_aes_sbox
//
// Directed testbench for canright_aes_sbox. Expected values come from
// hand-written FIPS-197 vectors. The exhaustive sweeps use a
// polynomial-basis reference model (x^254 followed by the bitwise affine
// map).
// ============================================================================
module tb_canright_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic       encrypt;
    logic [7:0] Q;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    canright_aes_sbox dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .encrypt (encrypt),
        .Q       (Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = ref_mul(inv, x);
        c = 8'h63;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                   inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    // Apply one input for one clock, then sample 1 ns after the edge
    task automatic step(input logic [7:0] a, input logic e);
        A       = a;
        encrypt = e;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b1;
        A       = 8'h01;
        encrypt = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Q !== 8'h00) begin
            errors++;
            $display("FAIL reset_async Q=%02h expected=00", Q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold Q=%02h expected=00", Q);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 8'h7C) begin
            errors++;
            $display("FAIL reset_release_first Q=%02h expected=7C", Q);
        end
    endtask

    task automatic test_forward_spot();
        logic [7:0] vin [8];
        logic [7:0] vexp [8];
        vin  = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h02, 8'h09, 8'h0F, 8'h10};
        vexp = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'h77, 8'h01, 8'h76, 8'hCA};
        for (int i = 0; i < 8; i++) begin
            step(vin[i], 1'b1);
            checks++;
            if (Q !== vexp[i]) begin
                errors++;
                $display("FAIL fwd_spot A=%02h Q=%02h expected=%02h", vin[i], Q, vexp[i]);
            end
        end
    endtask

    task automatic test_inverse_spot();
        logic [7:0] vin [8];
        logic [7:0] vexp [8];
        vin  = '{8'h63, 8'hED, 8'h16, 8'h00, 8'h7C, 8'h01, 8'h77, 8'hCA};
        vexp = '{8'h00, 8'h53, 8'hFF, 8'h52, 8'h01, 8'h09, 8'h02, 8'h10};
        for (int i = 0; i < 8; i++) begin
            step(vin[i], 1'b0);
            checks++;
            if (Q !== vexp[i]) begin
                errors++;
                $display("FAIL inv_spot A=%02h Q=%02h expected=%02h", vin[i], Q, vexp[i]);
            end
        end
    endtask

    task automatic test_forward_exhaustive();
        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b1);
            checks++;
            if (Q !== fwd_tab[i]) begin
                errors++;
                $display("FAIL fwd_exh A=%02h Q=%02h expected=%02h", i[7:0], Q, fwd_tab[i]);
            end
        end
    endtask

    task automatic test_inverse_exhaustive();
        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b0);
            checks++;
            if (Q !== inv_tab[i]) begin
                errors++;
                $display("FAIL inv_exh A=%02h Q=%02h expected=%02h", i[7:0], Q, inv_tab[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b1);
            step(Q, 1'b0);
            checks++;
            if (Q !== 8'(i)) begin
                errors++;
                $display("FAIL round_trip x=%02h Q=%02h expected=%02h", i[7:0], Q, i[7:0]);
            end
        end
    endtask

    task automatic test_mode_toggle();
        logic       mode [3];
        logic [7:0] vexp [3];
        mode = '{1'b1, 1'b0, 1'b1};
        vexp = '{8'hED, 8'h50, 8'hED};
        for (int i = 0; i < 3; i++) begin
            step(8'h53, mode[i]);
            checks++;
            if (Q !== vexp[i]) begin
                errors++;
                $display("FAIL mode_toggle step=%0d Q=%02h expected=%02h", i, Q, vexp[i]);
            end
        end
    endtask

    task automatic test_latency();
        step(8'h00, 1'b1);
        checks++;
        if (Q !== 8'h63) begin
            errors++;
            $display("FAIL latency_edge_n Q=%02h expected=63", Q);
        end
        A = 8'hFF;
        #4;
        checks++;
        if (Q !== 8'h63) begin
            errors++;
            $display("FAIL latency_hold Q=%02h expected=63", Q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 8'h16) begin
            errors++;
            $display("FAIL latency_edge_n1 Q=%02h expected=16", Q);
        end
    endtask

    task automatic test_reset_midstream();
        step(8'h53, 1'b1);
        checks++;
        if (Q !== 8'hED) begin
            errors++;
            $display("FAIL midreset_pre Q=%02h expected=ED", Q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Q !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async Q=%02h expected=00", Q);
        end
        A       = 8'h01;
        encrypt = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 8'h7C) begin
            errors++;
            $display("FAIL midreset_release Q=%02h expected=7C", Q);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fwd_tab[i] = ref_sbox(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        test_reset();
        test_forward_spot();
        test_inverse_spot();
        test_latency();
        test_mode_toggle();
        test_forward_exhaustive();
        test_inverse_exhaustive();
        test_round_trip();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
